// File: rtl/cop_wb_buf_pkg.sv
// Shared co-processor definitions: custom opcodes, instruction field positions
// and the default result width used by the write-back buffer.
package cop_wb_buf_pkg;

  localparam int unsigned COP_XLEN = 64;

  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 7;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  typedef logic [4:0] reg_idx_t;

  function automatic reg_idx_t insn_rd(input logic [31:0] insn);
    return insn[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [31:0] idx_onehot(input reg_idx_t idx);
    return 32'h0000_0001 << idx;
  endfunction

  function automatic logic is_custom(input logic [31:0] insn);
    return (insn[6:0] == CUSTOM_0) || (insn[6:0] == CUSTOM_1) ||
           (insn[6:0] == CUSTOM_2) || (insn[6:0] == CUSTOM_3);
  endfunction

endpackage

// File: rtl/cop_wb_fifo.sv
// Generic circular FIFO with read/write pointers and an occupancy count.
// Exposes every slot and its validity so the owner can scan buffered entries.
module cop_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 69
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [W-1:0]              wdata_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [W-1:0]              rdata_o,
  output logic [DEPTH-1:0][W-1:0]   mem_o,
  output logic [DEPTH-1:0]          slot_valid_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][W-1:0]  mem_q;
  logic                     push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i & ~full_o & ~clr_i;
  assign pop_ok_s  = pop_i & ~empty_o & ~clr_i;

  // Next-state for pointers and count; clear overrides push/pop.
  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign mem_o   = mem_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off_s;
    assign off_s           = PW'(g) - rd_ptr_q;
    assign slot_valid_o[g] = ({1'b0, off_s} < count_q);
  end

endmodule

// File: rtl/cop_wb_buf.sv
// Co-processor write-back buffer: queues results bound for the register file,
// filters x0 destinations and reports which registers have pending writes.
module cop_wb_buf
  import cop_wb_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = COP_XLEN
) (
  input  logic            cop_clk,
  input  logic            cop_rst,
  input  logic            cop_wr,
  input  logic [31:0]     cop_insn,
  input  logic [XLEN-1:0] cop_rd,
  output logic            cop_rdywr,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_idx,
  output logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [31:0]     pend_mask
);

  localparam int unsigned W = XLEN + 5;

  logic                     full_s, empty_s;
  logic                     push_s, pop_s;
  reg_idx_t                 rd_idx_s;
  logic [W-1:0]             rdata_s;
  logic [DEPTH-1:0][W-1:0]  mem_s;
  logic [DEPTH-1:0]         slot_valid_s;
  logic [31:0]              pend_mask_s;
  logic                     unused_s;

  assign rd_idx_s = insn_rd(cop_insn);
  assign unused_s = ^{cop_insn[31:RD_MSB+1], cop_insn[RD_LSB-1:0]};

  assign cop_rdywr = ~full_s;
  assign wb_valid  = ~empty_s;

  // An accepted x0 result is consumed here and never reaches the FIFO.
  assign push_s = cop_wr & cop_rdywr & ~flush & (rd_idx_s != 5'd0);
  assign pop_s  = wb_valid & wb_ready & ~flush;

  cop_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk_i        (cop_clk),
    .rst_ni       (cop_rst),
    .clr_i        (flush),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .wdata_i      ({rd_idx_s, cop_rd}),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .rdata_o      (rdata_s),
    .mem_o        (mem_s),
    .slot_valid_o (slot_valid_s)
  );

  assign wb_idx  = rdata_s[W-1:XLEN];
  assign wb_data = rdata_s[XLEN-1:0];

  // Pending-register mask: OR of destination decodes over valid slots.
  always_comb begin
    pend_mask_s = {32{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid_s[i]) pend_mask_s = pend_mask_s | idx_onehot(mem_s[i][W-1:XLEN]);
      else                 pend_mask_s = pend_mask_s;
    end
    pend_mask_s[0] = 1'b0;
  end

  assign pend_mask = pend_mask_s;

endmodule

// File: tb/tb_cop_wb_buf.sv
// Directed bench for cop_wb_buf: reset, in-order drain, x0 drop,
// pointer wrap under simultaneous push/pop, flush priority, async reset.
module tb_cop_wb_buf;

  logic        cop_clk = 1'b0;
  logic        cop_rst;
  logic        cop_wr;
  logic [31:0] cop_insn;
  logic [63:0] cop_rd;
  logic        cop_rdywr;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_idx;
  logic [63:0] wb_data;
  logic        flush;
  logic [31:0] pend_mask;

  int tests = 0;
  int fails = 0;

  always #5 cop_clk = ~cop_clk;

  cop_wb_buf #(.DEPTH(2), .XLEN(64)) dut (
    .cop_clk   (cop_clk),
    .cop_rst   (cop_rst),
    .cop_wr    (cop_wr),
    .cop_insn  (cop_insn),
    .cop_rd    (cop_rd),
    .cop_rdywr (cop_rdywr),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .flush     (flush),
    .pend_mask (pend_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cop_clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] rd, input logic [63:0] data);
    cop_wr   = en;
    cop_insn = {20'h00000, rd, 7'b0001011};
    cop_rd   = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cop_rst  = 1'b0;
    wb_ready = 1'b0;
    flush    = 1'b0;
    set_wr(1'b0, 5'd0, 64'h0);
    #3;
    chk("rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_rdywr", {63'd0, cop_rdywr}, 64'd1);
    chk("rst_pend", {32'd0, pend_mask}, 64'd0);
    #10 cop_rst = 1'b1;
    tick();

    // Single push with wb_ready high: one-cycle visibility, then drained.
    wb_ready = 1'b1;
    set_wr(1'b1, 5'd5, 64'h1122334455667788);
    tick();
    set_wr(1'b0, 5'd0, 64'h0);
    chk("c1_valid", {63'd0, wb_valid}, 64'd1);
    chk("c1_idx", {59'd0, wb_idx}, 64'd5);
    chk("c1_data", wb_data, 64'h1122334455667788);
    chk("c1_pend", {32'd0, pend_mask}, 64'h20);
    tick();
    chk("c1_valid_after", {63'd0, wb_valid}, 64'd0);
    chk("c1_pend_after", {32'd0, pend_mask}, 64'd0);

    // Fill while stalled, reject a third, drain in order.
    wb_ready = 1'b0;
    set_wr(1'b1, 5'd3, 64'hAAAA_0000_0000_0003);
    tick();
    set_wr(1'b1, 5'd7, 64'hBBBB_0000_0000_0007);
    tick();
    chk("c2_rdywr_full", {63'd0, cop_rdywr}, 64'd0);
    chk("c2_pend", {32'd0, pend_mask}, 64'h88);
    set_wr(1'b1, 5'd12, 64'hCCCC_0000_0000_000C);
    tick();
    set_wr(1'b0, 5'd0, 64'h0);
    chk("c2_third_rejected", {32'd0, pend_mask}, 64'h88);
    chk("c2_hold_idx", {59'd0, wb_idx}, 64'd3);
    chk("c2_hold_data", wb_data, 64'hAAAA_0000_0000_0003);
    wb_ready = 1'b1;
    tick();
    chk("c2_second_idx", {59'd0, wb_idx}, 64'd7);
    chk("c2_second_data", wb_data, 64'hBBBB_0000_0000_0007);
    chk("c2_second_valid", {63'd0, wb_valid}, 64'd1);
    tick();
    chk("c2_drained", {63'd0, wb_valid}, 64'd0);

    // Result targeting x0 is dropped.
    wb_ready = 1'b0;
    set_wr(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    set_wr(1'b0, 5'd0, 64'h0);
    chk("c3_valid", {63'd0, wb_valid}, 64'd0);
    chk("c3_rdywr", {63'd0, cop_rdywr}, 64'd1);
    chk("c3_pend", {32'd0, pend_mask}, 64'd0);

    // Count held at 1 through simultaneous push/pop, wrapping pointers.
    set_wr(1'b1, 5'd4, 64'h44);
    tick();
    chk("c4_head4", {59'd0, wb_idx}, 64'd4);
    wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_wr(1'b1, 5'd9, 64'h900 + 64'(k));
      tick();
      chk("c4_wrap_valid", {63'd0, wb_valid}, 64'd1);
      chk("c4_wrap_idx", {59'd0, wb_idx}, 64'd9);
      chk("c4_wrap_data", wb_data, 64'h900 + 64'(k));
      chk("c4_wrap_rdywr", {63'd0, cop_rdywr}, 64'd1);
      chk("c4_wrap_pend", {32'd0, pend_mask}, 64'h200);
    end
    set_wr(1'b0, 5'd0, 64'h0);
    tick();
    chk("c4_empty", {63'd0, wb_valid}, 64'd0);

    // Flush in the full state beats a concurrent push.
    wb_ready = 1'b0;
    set_wr(1'b1, 5'd1, 64'h11);
    tick();
    set_wr(1'b1, 5'd2, 64'h22);
    tick();
    chk("c5_full", {63'd0, cop_rdywr}, 64'd0);
    flush    = 1'b1;
    wb_ready = 1'b1;
    set_wr(1'b1, 5'd6, 64'h66);
    tick();
    flush = 1'b0;
    set_wr(1'b0, 5'd0, 64'h0);
    chk("c5_valid", {63'd0, wb_valid}, 64'd0);
    chk("c5_pend", {32'd0, pend_mask}, 64'd0);
    chk("c5_rdywr", {63'd0, cop_rdywr}, 64'd1);
    tick();
    chk("c5_not_stored", {63'd0, wb_valid}, 64'd0);

    // Asynchronous reset between edges with two entries buffered.
    wb_ready = 1'b0;
    set_wr(1'b1, 5'd10, 64'hA0);
    tick();
    set_wr(1'b1, 5'd11, 64'hB0);
    tick();
    set_wr(1'b0, 5'd0, 64'h0);
    chk("c6_pend_before", {32'd0, pend_mask}, 64'hC00);
    #2 cop_rst = 1'b0;
    #1;
    chk("c6_valid_async", {63'd0, wb_valid}, 64'd0);
    chk("c6_pend_async", {32'd0, pend_mask}, 64'd0);
    chk("c6_rdywr_async", {63'd0, cop_rdywr}, 64'd1);
    #2 cop_rst = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("c6_no_stale", {63'd0, wb_valid}, 64'd0);
      chk("c6_no_stale_pend", {32'd0, pend_mask}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cop_wb_buf.md
COP_WB_BUF -- requirements
Module: cop_wb_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered write-back entries (power of two, 2..8).
REQ-002 SHALL have parameter XLEN, default 64, result data width.
REQ-003 SHALL have port cop_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port cop_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cop_wr  input  1  co-processor result valid for the current instruction.
REQ-006 SHALL have port cop_insn  input  32  issued instruction; destination index taken from cop_insn[11:7].
REQ-007 SHALL have port cop_rd  input  XLEN  co-processor result data.
REQ-008 SHALL have port cop_rdywr  output  1  buffer can accept a result this cycle.
REQ-009 SHALL have port wb_valid  output  1  head entry presented to the register-file write port.
REQ-010 SHALL have port wb_ready  input  1  register file accepts the head entry this cycle.
REQ-011 SHALL have port wb_idx  output  5  destination register of the head entry.
REQ-012 SHALL have port wb_data  output  XLEN  data of the head entry.
REQ-013 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-014 SHALL have port pend_mask  output  32  bit i set while any buffered entry targets register i.

Function
REQ-015 SHALL hold entries in a circular FIFO of DEPTH slots, with a read pointer, a write pointer and an occupancy count of 0..DEPTH.
REQ-016 SHALL drive cop_rdywr = (count != DEPTH); when full, cop_rdywr is 0 even if a pop occurs in the same cycle (no full-state bypass).
REQ-017 SHALL push {cop_insn[11:7], cop_rd} when cop_wr && cop_rdywr && !flush && cop_insn[11:7] != 0.
REQ-018 SHALL silently drop an accepted result whose destination is x0; no push occurs and count is unchanged.
REQ-019 SHALL pop the head when wb_valid && wb_ready && !flush.
REQ-020 SHALL drive wb_valid = (count != 0); wb_idx and wb_data come from registered storage at the read pointer, with no combinational path from cop_rd.
REQ-021 SHALL give one-cycle latency: a push into an empty buffer appears on wb_valid in the next cycle.
REQ-022 SHALL hold wb_idx and wb_data stable while wb_valid=1 and wb_ready=0.
REQ-023 SHALL apply a simultaneous push and pop when 0<count<DEPTH, leaving count unchanged and advancing both pointers.
REQ-024 SHALL wrap both pointers modulo DEPTH.
REQ-025 SHALL, on flush, reset count and both pointers to 0 at the next edge; flush takes priority over a push or pop in the same cycle.
REQ-026 SHALL compute pend_mask combinationally as the OR of the one-hot decodes of wb_idx over all valid entries; bit 0 is always 0.
REQ-027 SHALL keep entries in order; the write-back order equals the acceptance order.

Reset
REQ-028 SHALL, when cop_rst=0, asynchronously clear count and pointers, giving wb_valid=0, pend_mask=0 and cop_rdywr=1.
REQ-029 SHALL discard all in-flight entries when reset is asserted mid-operation; no entry is written back after reset is released.
REQ-030 SHALL leave data storage unreset.

Structure
REQ-031 SHALL take CUSTOM_0..CUSTOM_3 opcodes, the RD field position (11:7) and default XLEN from the shared co-processor package.
REQ-032 SHALL contain one sub-module, cop_wb_fifo (generic pointer/count FIFO); the x0 filter, pend_mask logic and flush gating live in cop_wb_buf.

Verification
REQ-033 SHALL cover this case: on an empty buffer, push rd=5, data=0x1122334455667788, wb_ready=1 -> next cycle wb_valid=1, wb_idx=5, wb_data matches, pend_mask=0x20; the following cycle wb_valid=0.
REQ-034 SHALL cover this case: with wb_ready=0, push rd=3 then rd=7 -> cop_rdywr=0 and pend_mask=0x88; a third cop_wr is not accepted; with wb_ready=1, the entries drain in order 3 then 7.
REQ-035 SHALL cover this case: cop_wr with rd=0 and data 0xFFFF... -> wb_valid stays 0 and count stays 0.
REQ-036 SHALL cover this case: with count=1, push rd=9 while popping rd=4 -> count stays 1 and head becomes rd=9; repeat 10 times to exercise pointer wrap with no loss.
REQ-037 SHALL cover this case: in the full state, assert flush together with cop_wr -> next cycle wb_valid=0, pend_mask=0, cop_rdywr=1, and the concurrent result is not stored.
REQ-038 SHALL cover this case: pulse cop_rst low asynchronously between clock edges with 2 entries buffered -> outputs clear immediately, and no stale write-back occurs after release.
